// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble-validity helper used by the counter
// and its digit slices.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_counter_if.sv
// Control and data bundle between the counter and its driver (divider/host).
// The master drives the strobes and load value; the slave is the counter.
interface bcd_counter_if #(
    parameter int unsigned NDIG = 4
);
    import bcd_pkg::*;

    logic                    tick_i;
    logic                    en_i;
    logic                    up_i;
    logic                    load_i;
    logic [DIGIT_W*NDIG-1:0] load_val_i;
    logic [DIGIT_W*NDIG-1:0] cnt_o;
    logic                    carry_o;
    logic                    err_o;

    modport master (
        output tick_i, en_i, up_i, load_i, load_val_i,
        input  cnt_o, carry_o, err_o
    );

    modport slave (
        input  tick_i, en_i, up_i, load_i, load_val_i,
        output cnt_o, carry_o, err_o
    );

endinterface : bcd_counter_if

// File: rtl/bcd_digit.sv
// One BCD decade: loads, steps up or down with 9<->0 roll, and reports
// whether it sits at 9 or 0 so the top level can build the step enables.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               step_i,
    input  logic               up_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_d_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               at_max_o,
    output logic               at_min_o
);

    logic [DIGIT_W-1:0] r_digit;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and every state update uses non-blocking assignment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_digit <= BCD_MIN;
        end else if (load_i) begin
            r_digit <= load_d_i;
        end else if (step_i) begin
            if (up_i) begin
                r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign digit_o  = r_digit;
    assign at_max_o = (r_digit == BCD_MAX);
    assign at_min_o = (r_digit == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_counter.sv
// Multi-digit up/down BCD counter with validated parallel load and a
// registered wrap pulse; counts on tick_i & en_i.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bcd_counter_if.slave bus
);

    logic [NDIG:0]           w_pre_max;
    logic [NDIG:0]           w_pre_min;
    logic [NDIG-1:0]         w_at_max;
    logic [NDIG-1:0]         w_at_min;
    logic [NDIG-1:0]         w_step;
    logic [DIGIT_W*NDIG-1:0] w_cnt;
    logic                    w_load_ok;
    logic                    w_count;
    logic                    w_wrap;
    logic                    r_carry;
    logic                    r_err;

    // NOTE: the flag gets its default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_load_ok = 1'b1;
        for (int k = 0; k < int'(NDIG); k++) begin
            if (!is_bcd(bus.load_val_i[k*DIGIT_W +: DIGIT_W])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // A coincident load wins over the tick, and the tick is simply lost.
    assign w_count = bus.tick_i & bus.en_i & ~bus.load_i;

    // Prefix ANDs: digit k steps when every lower digit is at the roll value.
    assign w_pre_max[0] = 1'b1;
    assign w_pre_min[0] = 1'b1;

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        assign w_pre_max[k+1] = w_pre_max[k] & w_at_max[k];
        assign w_pre_min[k+1] = w_pre_min[k] & w_at_min[k];
        assign w_step[k]      = w_count & (bus.up_i ? w_pre_max[k] : w_pre_min[k]);

        bcd_digit u_digit (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .step_i   (w_step[k]),
            .up_i     (bus.up_i),
            .load_i   (bus.load_i & w_load_ok),
            .load_d_i (bus.load_val_i[k*DIGIT_W +: DIGIT_W]),
            .digit_o  (w_cnt[k*DIGIT_W +: DIGIT_W]),
            .at_max_o (w_at_max[k]),
            .at_min_o (w_at_min[k])
        );
    end

    assign w_wrap = w_count & (bus.up_i ? w_pre_max[NDIG] : w_pre_min[NDIG]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_carry <= w_wrap;
            r_err   <= bus.load_i & ~w_load_ok;
        end
    end

    assign bus.cnt_o   = w_cnt;
    assign bus.carry_o = r_carry;
    assign bus.err_o   = r_err;

endmodule : bcd_counter
